// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types and constants for the 32x32 -> 64 sequential multiplier.
//   mult_state_t : FSM state encoding (SETUP / RUN / FIX / DONE)
//   DATA_W       : operand width
//   MULT_ITERS   : shift-add iterations per multiply
//   mag32()      : operand magnitude for signed or unsigned mode
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int DATA_W     = 32;
    localparam int MULT_ITERS = 32;
    localparam int CNT_W      = 6;

    // Plain 2-bit constants rather than an enum so the encoding stays visible
    // to tools and netlists that predate SV enums.
    typedef logic [1:0] mult_state_t;
    localparam mult_state_t SETUP = 2'd0;
    localparam mult_state_t RUN   = 2'd1;
    localparam mult_state_t FIX   = 2'd2;
    localparam mult_state_t DONE  = 2'd3;

    // Two's-complement magnitude when signed; 0x80000000 negates to itself,
    // which read as unsigned is exactly the magnitude wanted.
    function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] v,
                                                input logic              is_signed);
        if (is_signed && v[DATA_W-1]) begin
            return -v;
        end
        return v;
    endfunction

endpackage

// File: rtl/mult_if.sv
// -----------------------------------------------------------------------------
// mult_if
// Operand / result bundle for the multiplier.
//   a, b, signmult : operands and signed-mode select (master -> slave)
//   hi, lo, done   : 64-bit product halves and result-valid flag (slave -> master)
// -----------------------------------------------------------------------------
interface mult_if;
    import mult_pkg::*;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              signmult;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              done;

    modport master (
        output a, b, signmult,
        input  hi, lo, done
    );

    modport slave (
        input  a, b, signmult,
        output hi, lo, done
    );

endinterface

// File: rtl/mult.sv
// -----------------------------------------------------------------------------
// mult
// Sequential 32x32 -> 64 shift-add multiplier, signed (MULT) or unsigned
// (MULTU). A high multrst both resets the block and captures the operands;
// the result appears 34 edges after the last edge with multrst high.
//
// Ports
//   clk      : rising-edge clock
//   multrst  : synchronous active-high reset / operand load / start
//   bus      : mult_if.slave -- a, b, signmult in; hi, lo, done out
//
// State table
//   SETUP | operands captured; form magnitudes and sign, clear accumulator
//   RUN   | one shift-add iteration per edge, 32 in total
//   FIX   | apply the sign to the accumulator and write hi:lo
//   DONE  | result valid, held until the next multrst
// -----------------------------------------------------------------------------
module mult
    import mult_pkg::*;
(
    input  logic clk,
    input  logic multrst,
    mult_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULT_ITERS - 1);

    mult_state_t         state_q,  state_d;
    logic [DATA_W-1:0]   a_q,      a_d;
    logic [DATA_W-1:0]   b_q,      b_d;
    logic                sm_q,     sm_d;
    logic                sign_q,   sign_d;
    logic [2*DATA_W-1:0] mcand_q,  mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [2*DATA_W-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [DATA_W-1:0]   hi_q,     hi_d;
    logic [DATA_W-1:0]   lo_q,     lo_d;

    logic [2*DATA_W-1:0] prod;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sm_d     = sm_q;
        sign_d   = sign_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        prod     = sign_q ? -acc_q : acc_q;

        case (state_q)
            SETUP: begin
                mcand_d  = {{DATA_W{1'b0}}, mag32(a_q, sm_q)};
                mplier_d = mag32(b_q, sm_q);
                sign_d   = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) & sm_q;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = RUN;
            end
            RUN: begin
                // Multiplicand walks left while the multiplier walks right,
                // so bit 0 of the multiplier is always the current bit.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = prod[2*DATA_W-1:DATA_W];
                lo_d    = prod[DATA_W-1:0];
                state_d = DONE;
            end
            default: begin
                state_d = DONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (multrst) begin
            state_q  <= SETUP;
            a_q      <= bus.a;
            b_q      <= bus.b;
            sm_q     <= bus.signmult;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sm_q     <= sm_d;
            sign_q   <= sign_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_mult.sv
// -----------------------------------------------------------------------------
// tb_mult
// Directed vectors for the sequential multiplier. The stimulus side pushes the
// expected product and its start edge into a queue; the monitor checks the
// cleared outputs right after the start edge, done=0 while busy, done and hi/lo
// exactly 34 edges later, and a stable hold afterwards.
// -----------------------------------------------------------------------------
module tb_mult;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          e0;
    } exp_t;

    logic clk;
    logic multrst;
    int   cyc;
    int   checks;
    int   errors;

    exp_t        q[$];
    logic        hold_valid;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    logic        toggle_en;

    mult_if bus ();

    mult dut (
        .clk     (clk),
        .multrst (multrst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Operand noise after the start edge must not reach the result.
    always @(posedge clk) begin
        #1;
        if (toggle_en) begin
            bus.a = $urandom;
            bus.b = $urandom;
        end
    end

    // Monitor: sampled on the falling edge, half a cycle from the DUT's edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            int n;
            n = cyc - q[0].e0;
            if (n == 0) begin
                checks = checks + 1;
                if (bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
                    errors = errors + 1;
                    $display("FAIL reset_state: done=%b hi=%h lo=%h, required done=0 hi=0 lo=0",
                             bus.done, bus.hi, bus.lo);
                end
            end else if (n > 0 && n < 34) begin
                checks = checks + 1;
                if (bus.done !== 1'b0) begin
                    errors = errors + 1;
                    $display("FAIL busy_done: edge E%0d done=%b, required 0", n, bus.done);
                end
            end else if (n == 34) begin
                checks = checks + 1;
                if (bus.done !== 1'b1 || bus.hi !== q[0].hi || bus.lo !== q[0].lo) begin
                    errors = errors + 1;
                    $display("FAIL result: done=%b hi=%h lo=%h, required done=1 hi=%h lo=%h",
                             bus.done, bus.hi, bus.lo, q[0].hi, q[0].lo);
                end
                hold_hi    = q[0].hi;
                hold_lo    = q[0].lo;
                hold_valid = 1'b1;
                void'(q.pop_front());
            end
        end else if (hold_valid) begin
            checks = checks + 1;
            if (bus.done !== 1'b1 || bus.hi !== hold_hi || bus.lo !== hold_lo) begin
                errors = errors + 1;
                $display("FAIL hold: done=%b hi=%h lo=%h, required done=1 hi=%h lo=%h",
                         bus.done, bus.hi, bus.lo, hold_hi, hold_lo);
            end
        end
    end

    // Starts a multiply. 'pre' extra reset edges carry decoy operands first so
    // that the last sampled set is the one that must win.
    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic sm,
                         input logic [31:0] eh, input logic [31:0] el, input int pre);
        exp_t e;
        @(posedge clk); #1;
        toggle_en  = 1'b0;
        hold_valid = 1'b0;
        q.delete();
        multrst = 1'b1;
        for (int i = 0; i < pre; i++) begin
            bus.a        = ~a;
            bus.b        = b ^ 32'h5A5A_0001;
            bus.signmult = ~sm;
            @(posedge clk); #1;
        end
        bus.a        = a;
        bus.b        = b;
        bus.signmult = sm;
        e.hi = eh;
        e.lo = el;
        e.e0 = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        multrst = 1'b0;
    endtask

    task automatic wait_result(input int hold_edges);
        int budget;
        budget = 60;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget = budget - 1;
        end
        if (q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL timeout: result still pending after 60 edges, required done within 34");
            q.delete();
        end
        repeat (hold_edges) @(posedge clk);
    endtask

    initial begin
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        hold_valid   = 1'b0;
        toggle_en    = 1'b0;
        multrst      = 1'b1;
        bus.a        = '0;
        bus.b        = '0;
        bus.signmult = 1'b0;
        repeat (2) @(posedge clk);

        start(32'hF000_0000, 32'h1000_0000, 1'b0, 32'h0F00_0000, 32'h0000_0000, 0);
        wait_result(3);
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001, 0);
        wait_result(2);
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        wait_result(2);
        start(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, 0);
        wait_result(2);
        start(32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        wait_result(2);
        start(32'h8000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        wait_result(2);
        start(32'hFFFF_FFFB, 32'h0000_0006, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 2);
        wait_result(2);
        start(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 3);
        wait_result(2);

        // Abort mid-RUN: the second start samples reset on edge E10 of the first.
        start(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0, 32'h0, 0);
        repeat (8) @(posedge clk);
        start(32'h0000_0003, 32'h0000_0005, 1'b0, 32'h0000_0000, 32'h0000_000F, 0);
        wait_result(2);

        start(32'h0000_0000, 32'hFFFF_FFF0, 1'b1, 32'h0000_0000, 32'h0000_0000, 0);
        toggle_en = 1'b1;
        wait_result(20);
        toggle_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult.md
MULT -- requirements
Module: mult

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 multrst  input  1  synchronous active-high reset; also loads operands and starts a multiply.
REQ-004 a  input  32  multiplicand; sampled only on edges with multrst=1.
REQ-005 b  input  32  multiplier; sampled only on edges with multrst=1.
REQ-006 signmult  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled only on edges with multrst=1.
REQ-007 hi  output  32  upper 32 bits of the 64-bit product.
REQ-008 lo  output  32  lower 32 bits of the 64-bit product.
REQ-009 done  output  1  high while hi/lo hold the valid result.

Function
REQ-010 The FSM SHALL have the states SETUP, RUN, FIX and DONE, advancing only on edges with multrst=0.
REQ-011 SETUP->RUN: latch |a| and |b| (two's-complement magnitude if signmult=1, else raw), latch sign = a[31]^b[31] & signmult, clear the 64-bit accumulator, set the iteration count to 0.
REQ-012 RUN: one shift-add iteration per edge (add the shifted multiplicand when the current multiplier bit is 1), count+1; after 32 iterations, go to FIX.
REQ-013 FIX->DONE: write hi:lo = sign ? -(accumulator) : accumulator, as 64-bit two's complement.
REQ-014 DONE SHALL hold, with hi/lo/done stable, until the next multrst.
REQ-015 Let E0 be the edge sampling multrst=1 and E1.. the following edges with multrst=0: state is RUN after E1, FIX after E33, and DONE with done=1 after E34 (34-cycle latency).
REQ-016 hi/lo SHALL change only at the FIX->DONE edge or on reset; done=1 iff state==DONE.
REQ-017 Changes on a, b or signmult after E0 SHALL NOT affect the result.
REQ-018 Magnitude of 0x80000000 SHALL be taken as unsigned 0x80000000 (no overflow); a zero product with sign=1 SHALL yield hi=lo=0.
REQ-019 All arithmetic SHALL be performed on a 64-bit accumulator with no truncation before the final write.

Reset
REQ-020 On any edge with multrst=1: hi=0, lo=0, done=0, state=SETUP, count=0, operands and signmult captured.
REQ-021 Reset in any state, including mid-RUN, SHALL abort the current operation and restart the latency count from that edge with the newly sampled operands.
REQ-022 multrst held high for several edges SHALL keep the block in SETUP, resampling operands on each edge; the last sample wins.

Structure
REQ-023 A shared package SHALL hold mult_state_t (SETUP/RUN/FIX/DONE), the constant MULT_ITERS=32 and the constant DATA_W=32.
REQ-024 The block SHALL be a single module with no sub-module; the accumulator, shifter and adder are inline.

Verification
REQ-025 Unsigned 0xF0000000 x 0x10000000 -> after E34: hi=0x0F000000, lo=0x00000000, done=1; done=0 at E1..E33.
REQ-026 0xFFFFFFFF x 0xFFFFFFFF: signed -> hi=0x00000000, lo=0x00000001; unsigned -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-027 Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; signed 7 x 0xFFFFFFFD -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-028 Start 0x12345678 x 0x9ABCDEF0, then assert reset at E10 with operands 3 x 5 (unsigned) -> done=0 for 34 edges after the new reset, then hi=0, lo=15.
REQ-029 Signed 0 x 0xFFFFFFF0, with a and b toggled randomly after E0 -> hi=lo=0 at done; done stays 1 and hi/lo stay stable for 20 further edges.
